// File: rtl/afe_serial_tx.sv
// rtl/afe_serial_tx.sv - AFE sample frame serializer: start, channel, 16 data bits MSB first, gap.
// Optional internal ramp pattern source under AFE_SERIAL_TX_TEST_PATTERN_EN.
module afe_serial_tx #(
  parameter int GAP_CYCLES = 1,
  parameter int FCW        = 16
) (
  input  logic           clk,
  input  logic           reset,
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
  input  logic           test_mode,
`endif
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_channel,
  input  logic [15:0]    in_data,
  output logic           tx_bit,
  output logic           busy,
  output logic           frame_done,
  output logic [FCW-1:0] frames_sent
);

  typedef enum logic [2:0] {IDLE, START, CHAN, DATA, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t         state_q, state_d;
  logic           hold_valid_q, hold_valid_d;
  logic           hold_ch_q, hold_ch_d;
  logic [15:0]    hold_data_q, hold_data_d;
  logic           ready_q, ready_d;
  logic           sh_ch_q, sh_ch_d;
  logic [15:0]    sh_data_q, sh_data_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     gap_q, gap_d;
  logic           tx_q, tx_d;
  logic [FCW-1:0] fs_q, fs_d;
  logic           src_valid, src_ch, launch, accept;
  logic [15:0]    src_data;
  logic [3:0]     idx_n;
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
  logic           pat_ch_q, pat_ch_d;
  logic [15:0]    pat_data_q, pat_data_d;

  assign in_ready = ready_q & ~test_mode;
`else
  assign in_ready = ready_q;
`endif

  assign accept      = in_valid & in_ready;
  assign idx_n       = idx_q - 4'd1;
  assign tx_bit      = tx_q;
  assign busy        = (state_q != IDLE) || hold_valid_q;
  assign frame_done  = (state_q == GAP) && (gap_q == 4'd0);
  assign frames_sent = fs_q;

  always_comb begin
    state_d     = state_q;
    hold_valid_d = hold_valid_q;
    hold_ch_d   = hold_ch_q;
    hold_data_d = hold_data_q;
    sh_ch_d     = sh_ch_q;
    sh_data_d   = sh_data_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    tx_d        = 1'b0;
    fs_d        = fs_q;
    launch      = 1'b0;
    src_valid   = hold_valid_q;
    src_ch      = hold_ch_q;
    src_data    = hold_data_q;
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
    pat_ch_d    = pat_ch_q;
    pat_data_d  = pat_data_q;
    // A held sample always goes out before the internal pattern resumes.
    if (!hold_valid_q && test_mode) begin
      src_valid = 1'b1;
      src_ch    = pat_ch_q;
      src_data  = pat_data_q;
    end
`endif

    case (state_q)
      IDLE: launch = src_valid;
      START: begin
        state_d = CHAN;
        tx_d    = sh_ch_q;
      end
      CHAN: begin
        state_d = DATA;
        idx_d   = 4'd15;
        tx_d    = sh_data_q[15];
      end
      DATA: begin
        if (idx_q == 4'd0) begin
          state_d = GAP;
          gap_d   = GAP_LAST;
        end else begin
          idx_d = idx_n;
          tx_d  = sh_data_q[idx_n];
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          fs_d    = fs_q + {{(FCW-1){1'b0}}, 1'b1};
          state_d = IDLE;
          launch  = src_valid;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d   = START;
      sh_ch_d   = src_ch;
      sh_data_d = src_data;
      tx_d      = 1'b1;
      if (hold_valid_q) begin
        hold_valid_d = 1'b0;
      end
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
      else begin
        pat_ch_d   = ~pat_ch_q;
        pat_data_d = pat_data_q + 16'd1;
      end
`endif
    end

    // Accept only happens with the register empty, so it never collides with a launch.
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_ch_d    = in_channel;
      hold_data_d  = in_data;
    end
    ready_d = ~hold_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_ch_q    <= 1'b0;
      hold_data_q  <= 16'd0;
      ready_q      <= 1'b1;
      sh_ch_q      <= 1'b0;
      sh_data_q    <= 16'd0;
      idx_q        <= 4'd0;
      gap_q        <= 4'd0;
      tx_q         <= 1'b0;
      fs_q         <= '0;
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
      pat_ch_q     <= 1'b0;
      pat_data_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_ch_q    <= hold_ch_d;
      hold_data_q  <= hold_data_d;
      ready_q      <= ready_d;
      sh_ch_q      <= sh_ch_d;
      sh_data_q    <= sh_data_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      tx_q         <= tx_d;
      fs_q         <= fs_d;
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
      pat_ch_q     <= pat_ch_d;
      pat_data_q   <= pat_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_afe_serial_tx.sv
// tb/tb_afe_serial_tx.sv - directed vector bench for afe_serial_tx.
module tb_afe_serial_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_channel = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready, tx_bit, busy, frame_done;
  logic [15:0] frames_sent;
  logic        v2 = 1'b0, ch2 = 1'b0;
  logic [15:0] d2 = 16'd0;
  logic        rdy2, tx2, busy2, fd2;
  logic [1:0]  fs2;
  logic        tm = 1'b0, tm2 = 1'b0;

  int total = 0;
  int bad = 0;
  int exp_fs = 0;

  always #5 clk = ~clk;

  afe_serial_tx #(.GAP_CYCLES(1), .FCW(16)) dut (
    .clk(clk), .reset(reset),
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel), .in_data(in_data),
    .tx_bit(tx_bit), .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
  );

  afe_serial_tx #(.GAP_CYCLES(4), .FCW(2)) dut2 (
    .clk(clk), .reset(reset),
`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
    .test_mode(tm2),
`endif
    .in_valid(v2), .in_ready(rdy2), .in_channel(ch2), .in_data(d2),
    .tx_bit(tx2), .busy(busy2), .frame_done(fd2), .frames_sent(fs2)
  );

  typedef struct {
    logic        ch;
    logic [15:0] data;
    logic [17:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic ch, input logic [15:0] d, input logic [17:0] exp, input string nm);
    logic [17:0] got;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk({nm, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_channel = ch;
    in_data = d;
    tick();
    in_valid = 1'b0;
    in_channel = ~ch;
    in_data = ~d;
    chk({nm, "_t1_tx"}, {busy, tx_bit}, 2'b10);
    tick();
    got = '0;
    for (int i = 0; i < 18; i++) begin
      got = {got[16:0], tx_bit};
      tick();
    end
    chk({nm, "_bits"}, got, exp);
    chk({nm, "_gap"}, {tx_bit, frame_done}, 2'b01);
    tick();
    exp_fs++;
    chk({nm, "_count"}, frames_sent, exp_fs);
  endtask

  initial begin
    logic [36:0] bb;
    logic [4:0]  hist;
    logic [1:0]  wexp[5];
    int nd, last, pend;

    vecs[0] = '{1'b1, 16'hA5C3, 18'h3A5C3};
    vecs[1] = '{1'b0, 16'h0001, 18'h20001};
    vecs[2] = '{1'b1, 16'hFFFF, 18'h3FFFF};
    vecs[3] = '{1'b0, 16'h8000, 18'h28000};
    vecs[4] = '{1'b1, 16'h1234, 18'h31234};
    wexp[0] = 2'd1; wexp[1] = 2'd2; wexp[2] = 2'd3; wexp[3] = 2'd0; wexp[4] = 2'd1;

    repeat (3) tick();
    reset = 1'b0;
    chk("reset_state", {tx_bit, busy, frame_done, in_ready}, 4'b0001);
    chk("reset_count", frames_sent, 0);

    for (int i = 0; i < 5; i++) send_frame(vecs[i].ch, vecs[i].data, vecs[i].frame, $sformatf("vec%0d", i));

    // back-to-back with in_valid held
    in_valid = 1'b1; in_channel = 1'b0; in_data = 16'h0001;
    tick();
    chk("b2b_hold_full", in_ready, 0);
    in_channel = 1'b1; in_data = 16'hFFFF;
    tick();
    bb = '0;
    bb = {bb[35:0], tx_bit};
    tick();
    in_valid = 1'b0;
    chk("b2b_second_held", {in_ready, busy}, 2'b01);
    for (int i = 1; i < 37; i++) begin
      bb = {bb[35:0], tx_bit};
      tick();
    end
    chk("b2b_bits", bb, {18'h20001, 1'b0, 18'h3FFFF});
    chk("b2b_done", frame_done, 1);
    tick();
    exp_fs += 2;
    chk("b2b_count", frames_sent, exp_fs);

    // reset during data bit 7, with a second sample queued
    in_valid = 1'b1; in_channel = 1'b1; in_data = 16'hFFFF;
    tick();
    in_data = 16'h1234;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("rst_bit7", tx_bit, 1);
    reset = 1'b1;
    tick();
    chk("rst_mid", {tx_bit, in_ready, busy}, 3'b010);
    chk("rst_count", frames_sent, 0);
    reset = 1'b0;
    exp_fs = 0;
    send_frame(1'b1, 16'hA5C3, 18'h3A5C3, "post_rst");

    // GAP_CYCLES=4, FCW=2 instance: gap length, spacing, wrap
    v2 = 1'b1; ch2 = 1'b1; d2 = 16'hFFFF;
    nd = 0; last = 0; pend = 0; hist = '0;
    for (int c = 0; c < 400 && (nd < 5 || pend != 0); c++) begin
      tick();
      hist = {hist[3:0], tx2};
      if (pend != 0) begin
        chk($sformatf("wrap%0d", nd), fs2, wexp[nd-1]);
        pend = 0;
      end
      if (fd2) begin
        nd++;
        chk($sformatf("gap4_%0d", nd), hist, 5'b10000);
        if (nd > 1) chk($sformatf("spacing%0d", nd), c - last, 22);
        last = c;
        pend = 1;
      end
    end
    chk("g4_frames", nd, 5);
    v2 = 1'b0;

`ifdef AFE_SERIAL_TX_TEST_PATTERN_EN
    begin
      logic [56:0] pb;
      int w, rdy_seen;
      tm = 1'b1;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      w = 0;
      while (!tx_bit && w < 10) begin
        tick();
        w++;
      end
      pb = '0;
      rdy_seen = 0;
      for (int i = 0; i < 57; i++) begin
        pb = {pb[55:0], tx_bit};
        if (in_ready) rdy_seen++;
        tick();
      end
      chk("pat_bits", pb, {18'h20000, 1'b0, 18'h30001, 1'b0, 18'h20002, 1'b0});
      chk("pat_ready", rdy_seen, 0);
      tm = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
